// File: rtl/sga_input_pkg.sv
// sga_input_pkg: direction encodings, button indices and helpers for the input conditioner
package sga_input_pkg;
   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;
   localparam int BTN_LEFT  = 3;
   localparam int BTN_UP    = 2;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_RIGHT = 0;
   // Opposite directions are bitwise inverses under this encoding
   function automatic logic [1:0] dir_opposite(input logic [1:0] d);
      return ~d;
   endfunction
endpackage

// File: rtl/sga_debounce.sv
// sga_debounce: two-flop synchroniser, stability counter, stable level and registered rising-edge pulse
module sga_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic pulse
);
   logic             sync1_q, sync2_q, stable_q, stable_d, prev_q, pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
         else cnt_d = cnt_q + 1'b1;
      end
      pulse_d = stable_q & ~prev_q;
   end
   // Synchroniser, debounce state and edge-pulse registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         pulse_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         pulse_q  <= pulse_d;
         cnt_q    <= cnt_d;
      end
   end
   assign level = stable_q;
   assign pulse = pulse_q;
endmodule

// File: rtl/sga_input_conditioner.sv
// sga_input_conditioner: debounces board inputs and queues direction changes with reversal rejection
module sga_input_conditioner
   import sga_input_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = 50000,
   parameter int         CNT_W           = 16,
   parameter logic [1:0] RESET_DIR       = DIR_RIGHT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] buttons_raw,
   input  logic       start_raw,
   input  logic       pause_raw,
   input  logic       clear,
   input  logic       dir_take,
   output logic [3:0] buttons,
   output logic [3:0] button_pulse,
   output logic       start_pulse,
   output logic       pause_level,
   output logic       played,
   output logic [1:0] direction,
   output logic       pending_valid
);
   logic       unused_start_level, unused_pause_pulse, accept;
   logic [1:0] cand, ref_dir, dir_q, dir_d, pend_dir_q, pend_dir_d;
   logic       pv_q, pv_d;
   for (genvar g = 0; g < 4; g++) begin : g_btn
      sga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn (
         .clock(clock), .reset_n(reset_n), .raw(buttons_raw[g]),
         .level(buttons[g]), .pulse(button_pulse[g])
      );
   end
   sga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
      .clock(clock), .reset_n(reset_n), .raw(start_raw),
      .level(unused_start_level), .pulse(start_pulse)
   );
   sga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_pause (
      .clock(clock), .reset_n(reset_n), .raw(pause_raw),
      .level(pause_level), .pulse(unused_pause_pulse)
   );
   assign played = |button_pulse;
   // Pick the highest-priority press, check it against the queued or committed direction, then commit/clear
   always_comb begin
      cand = button_pulse[BTN_LEFT] ? DIR_LEFT :
             button_pulse[BTN_UP]   ? DIR_UP   :
             button_pulse[BTN_DOWN] ? DIR_DOWN : DIR_RIGHT;
      ref_dir    = pv_q ? pend_dir_q : dir_q;
      accept     = played && (cand != ref_dir) && (cand != dir_opposite(ref_dir));
      dir_d      = dir_q;
      pend_dir_d = pend_dir_q;
      pv_d       = pv_q;
      if (clear) begin
         dir_d = RESET_DIR;
         pv_d  = 1'b0;
      end else begin
         if (dir_take && pv_q) begin
            dir_d = pend_dir_q;
            pv_d  = 1'b0;
         end
         if (accept) begin
            pend_dir_d = cand;
            pv_d       = 1'b1;
         end
      end
   end
   // Committed and pending direction registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dir_q      <= RESET_DIR;
         pend_dir_q <= RESET_DIR;
         pv_q       <= 1'b0;
      end else begin
         dir_q      <= dir_d;
         pend_dir_q <= pend_dir_d;
         pv_q       <= pv_d;
      end
   end
   assign direction     = dir_q;
   assign pending_valid = pv_q;
endmodule

// File: tb/tb_sga_input_conditioner.sv
// tb_sga_input_conditioner: directed checks of debounce timing, pulses and direction queueing
module tb_sga_input_conditioner;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] buttons_raw = '0;
   logic       start_raw = 1'b0, pause_raw = 1'b0, clear = 1'b0, dir_take = 1'b0;
   logic [3:0] buttons, button_pulse;
   logic       start_pulse, pause_level, played, pending_valid;
   logic [1:0] direction;
   int         checks = 0;
   int         errors = 0;

   sga_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .RESET_DIR(2'b00)) dut (
      .clock(clock), .reset_n(reset_n), .buttons_raw(buttons_raw), .start_raw(start_raw),
      .pause_raw(pause_raw), .clear(clear), .dir_take(dir_take), .buttons(buttons),
      .button_pulse(button_pulse), .start_pulse(start_pulse), .pause_level(pause_level),
      .played(played), .direction(direction), .pending_valid(pending_valid)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] mask, input logic take);
      buttons_raw = mask;
      repeat (7) tick;
      dir_take = take;
      tick;
      dir_take = 1'b0;
      buttons_raw = '0;
      repeat (7) tick;
   endtask

   task automatic take_step;
      dir_take = 1'b1;
      tick;
      dir_take = 1'b0;
   endtask

   initial begin
      repeat (2) tick;
      chk("rst_buttons", buttons, 4'h0);
      chk("rst_pulse", button_pulse, 4'h0);
      chk("rst_start", {3'b0, start_pulse}, 4'h0);
      chk("rst_pause", {3'b0, pause_level}, 4'h0);
      chk("rst_played", {3'b0, played}, 4'h0);
      chk("rst_dir", {2'b0, direction}, 4'h0);
      chk("rst_pv", {3'b0, pending_valid}, 4'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         buttons_raw[0] = (i < 3) || (i >= 5 && i < 8);
         tick;
         chk("bounce_level", buttons, 4'h0);
         chk("bounce_pulse", button_pulse, 4'h0);
      end
      buttons_raw[0] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick;
         chk("hold_level", buttons, (i >= 6) ? 4'h1 : 4'h0);
         chk("hold_pulse", button_pulse, (i == 7) ? 4'h1 : 4'h0);
         chk("hold_played", {3'b0, played}, (i == 7) ? 4'h1 : 4'h0);
      end
      chk("right_same_pv", {3'b0, pending_valid}, 4'h0);
      buttons_raw = '0;
      for (int i = 1; i <= 7; i++) begin
         tick;
         chk("fall_pulse", button_pulse, 4'h0);
      end
      chk("fall_level", buttons, 4'h0);
      press(4'b1000, 1'b0);
      chk("rev_left_pv", {3'b0, pending_valid}, 4'h0);
      press(4'b0010, 1'b0);
      chk("down_pv", {3'b0, pending_valid}, 4'h1);
      take_step;
      chk("take_dir", {2'b0, direction}, 4'h1);
      chk("take_pv", {3'b0, pending_valid}, 4'h0);
      press(4'b1000, 1'b0);
      chk("left_pv", {3'b0, pending_valid}, 4'h1);
      press(4'b0001, 1'b0);
      press(4'b0100, 1'b0);
      take_step;
      chk("ovw_dir", {2'b0, direction}, 4'h2);
      take_step;
      chk("idle_take_dir", {2'b0, direction}, 4'h2);
      chk("idle_take_pv", {3'b0, pending_valid}, 4'h0);
      press(4'b0001, 1'b0);
      take_step;
      press(4'b0010, 1'b0);
      take_step;
      chk("prep_dir_down", {2'b0, direction}, 4'h1);
      press(4'b0101, 1'b0);
      chk("prio_rej_pv", {3'b0, pending_valid}, 4'h0);
      press(4'b0001, 1'b0);
      take_step;
      chk("prep_dir_right", {2'b0, direction}, 4'h0);
      press(4'b0101, 1'b0);
      chk("prio_acc_pv", {3'b0, pending_valid}, 4'h1);
      take_step;
      chk("prio_acc_dir", {2'b0, direction}, 4'h2);
      press(4'b0001, 1'b0);
      take_step;
      press(4'b0010, 1'b0);
      chk("sim_pre_dir", {2'b0, direction}, 4'h0);
      press(4'b1000, 1'b1);
      chk("sim_dir", {2'b0, direction}, 4'h1);
      chk("sim_pv", {3'b0, pending_valid}, 4'h1);
      take_step;
      chk("sim_take_dir", {2'b0, direction}, 4'h3);
      start_raw = 1'b1;
      pause_raw = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick;
         chk("pause_level", {3'b0, pause_level}, (i >= 6) ? 4'h1 : 4'h0);
         chk("start_pulse", {3'b0, start_pulse}, (i == 7) ? 4'h1 : 4'h0);
         chk("start_no_played", {3'b0, played}, 4'h0);
      end
      buttons_raw = 4'b0100;
      repeat (8) tick;
      chk("clr_pre_pv", {3'b0, pending_valid}, 4'h1);
      clear = 1'b1;
      dir_take = 1'b1;
      tick;
      clear = 1'b0;
      dir_take = 1'b0;
      chk("clr_dir", {2'b0, direction}, 4'h0);
      chk("clr_pv", {3'b0, pending_valid}, 4'h0);
      chk("clr_buttons", buttons, 4'b0100);
      chk("clr_pause", {3'b0, pause_level}, 4'h1);
      buttons_raw = 4'b1100;
      repeat (3) tick;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_buttons", buttons, 4'h0);
      chk("arst_pause", {3'b0, pause_level}, 4'h0);
      chk("arst_dir", {2'b0, direction}, 4'h0);
      chk("arst_pv", {3'b0, pending_valid}, 4'h0);
      repeat (2) tick;
      reset_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick;
         chk("rel_level", buttons, (i >= 6) ? 4'b1100 : 4'h0);
         chk("rel_pulse", button_pulse, (i == 7) ? 4'b1100 : 4'h0);
         chk("rel_played", {3'b0, played}, (i == 7) ? 4'h1 : 4'h0);
         chk("rel_start", {3'b0, start_pulse}, (i == 7) ? 4'h1 : 4'h0);
         chk("rel_pause", {3'b0, pause_level}, (i >= 6) ? 4'h1 : 4'h0);
      end
      chk("rel_left_rej_pv", {3'b0, pending_valid}, 4'h0);
      chk("rel_dir", {2'b0, direction}, 4'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
